// File: rtl/wallet_feature_accum_pkg.sv
// rtl/wallet_feature_accum_pkg.sv - shared types and defaults for the wallet feature path
package wallet_feature_accum_pkg;

   localparam int TS_W_D  = 10;
   localparam int VAL_W_D = 30;
   localparam int CNT_W_D = 7;
   localparam int SUM_W_D = 64;

   localparam logic [1:0] METHOD_FLAG = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_EMIT  = 2'd2
   } state_t;

   // Record handed to the scoring stage, laid out at the default widths
   typedef struct packed {
      logic [CNT_W_D-1:0] tx_count;
      logic [CNT_W_D-1:0] in_count;
      logic [CNT_W_D-1:0] method_count;
      logic               method_seen;
      logic [SUM_W_D-1:0] value_sum;
      logic [TS_W_D-1:0]  start_time;
      logic [TS_W_D-1:0]  end_time;
      logic [TS_W_D-1:0]  span;
      logic               sat;
   } feat_rec_t;

endpackage

// File: rtl/wallet_feature_accum_sat_counter.sv
// rtl/wallet_feature_accum_sat_counter.sv - loadable counter that sticks at all-ones
module sat_counter #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_inc,
   input  logic [W-1:0] i_load_val,
   output logic [W-1:0] o_count_nxt,
   output logic         o_sat
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] r_count;

   // Next value is exported so the owner can freeze it on the same edge it is written
   always_comb begin
      o_count_nxt = r_count;
      o_sat       = 1'b0;
      if (i_load) begin
         o_count_nxt = i_load_val;
      end else if (i_inc) begin
         if (r_count == MAX) begin
            o_sat = 1'b1;
         end else begin
            o_count_nxt = r_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= o_count_nxt;
      end
   end

endmodule

// File: rtl/wallet_feature_accum.sv
// rtl/wallet_feature_accum.sv - per-wallet statistics accumulator feeding the scorer
module wallet_feature_accum
   import wallet_feature_accum_pkg::*;
#(
   parameter int TS_W  = TS_W_D,
   parameter int VAL_W = VAL_W_D,
   parameter int CNT_W = CNT_W_D,
   parameter int SUM_W = SUM_W_D
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             tx_last,
   input  logic [TS_W-1:0]  time_stamp,
   input  logic             in,
   input  logic [1:0]       method_field,
   input  logic [VAL_W-1:0] value,
   output logic             feat_valid,
   input  logic             feat_ready,
   output logic [CNT_W-1:0] feat_tx_count,
   output logic [CNT_W-1:0] feat_in_count,
   output logic [CNT_W-1:0] feat_method_count,
   output logic             feat_method_seen,
   output logic [SUM_W-1:0] feat_value_sum,
   output logic [TS_W-1:0]  feat_start_time,
   output logic [TS_W-1:0]  feat_end_time,
   output logic [TS_W-1:0]  feat_span,
   output logic             feat_sat
);

   state_t r_state;
   state_t w_state_nxt;

   logic             w_accept;
   logic             w_first;
   logic             w_more;
   logic             w_hit;
   logic             w_emit_entry;

   logic [CNT_W-1:0] w_tx_nxt;
   logic [CNT_W-1:0] w_in_nxt;
   logic [CNT_W-1:0] w_meth_nxt;
   logic             w_tx_sat;
   logic             w_in_sat;
   logic             w_meth_sat;

   logic             r_seen;
   logic             w_seen_nxt;
   logic [SUM_W-1:0] r_sum;
   logic [SUM_W-1:0] w_sum_nxt;
   logic [SUM_W:0]   w_sum_add;
   logic             w_sum_sat;
   logic [TS_W-1:0]  r_start;
   logic [TS_W-1:0]  w_start_nxt;
   logic [TS_W-1:0]  r_end;
   logic [TS_W-1:0]  w_end_nxt;
   logic             r_sat;
   logic             w_sat_nxt;

   // Ready is forced low while reset is held so nothing upstream sees a phantom accept
   assign tx_ready     = rst_n && ((r_state == ST_IDLE) || (r_state == ST_ACCUM));
   assign feat_valid   = (r_state == ST_EMIT);
   assign w_accept     = tx_valid && tx_ready;
   assign w_first      = w_accept && (r_state == ST_IDLE);
   assign w_more       = w_accept && (r_state == ST_ACCUM);
   assign w_hit        = (method_field == METHOD_FLAG);
   assign w_emit_entry = w_accept && tx_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = tx_last ? ST_EMIT : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (w_accept && tx_last) begin
               w_state_nxt = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (feat_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   sat_counter #(.W(CNT_W)) u_tx_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_first),
      .i_inc       (w_more),
      .i_load_val  (CNT_W'(1)),
      .o_count_nxt (w_tx_nxt),
      .o_sat       (w_tx_sat)
   );

   sat_counter #(.W(CNT_W)) u_in_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_first),
      .i_inc       (w_more && in),
      .i_load_val  (CNT_W'(in)),
      .o_count_nxt (w_in_nxt),
      .o_sat       (w_in_sat)
   );

   sat_counter #(.W(CNT_W)) u_meth_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_first),
      .i_inc       (w_more && w_hit),
      .i_load_val  (CNT_W'(w_hit)),
      .o_count_nxt (w_meth_nxt),
      .o_sat       (w_meth_sat)
   );

   // One extra bit catches the carry out of the value sum
   assign w_sum_add = {1'b0, r_sum} + (SUM_W+1)'(value);
   assign w_sum_sat = w_more && w_sum_add[SUM_W];

   always_comb begin
      w_seen_nxt  = r_seen;
      w_sum_nxt   = r_sum;
      w_start_nxt = r_start;
      w_end_nxt   = r_end;
      w_sat_nxt   = r_sat;
      if (w_first) begin
         w_seen_nxt  = w_hit;
         w_sum_nxt   = SUM_W'(value);
         w_start_nxt = time_stamp;
         w_end_nxt   = time_stamp;
         w_sat_nxt   = 1'b0;
      end else if (w_more) begin
         w_seen_nxt = r_seen | w_hit;
         w_sum_nxt  = w_sum_add[SUM_W] ? {SUM_W{1'b1}} : w_sum_add[SUM_W-1:0];
         w_end_nxt  = time_stamp;
         w_sat_nxt  = r_sat | w_tx_sat | w_in_sat | w_meth_sat | w_sum_sat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seen  <= 1'b0;
         r_sum   <= '0;
         r_start <= '0;
         r_end   <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_seen  <= w_seen_nxt;
         r_sum   <= w_sum_nxt;
         r_start <= w_start_nxt;
         r_end   <= w_end_nxt;
         r_sat   <= w_sat_nxt;
      end
   end

   // The record freezes on the edge that accepts the last transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         feat_tx_count     <= '0;
         feat_in_count     <= '0;
         feat_method_count <= '0;
         feat_method_seen  <= 1'b0;
         feat_value_sum    <= '0;
         feat_start_time   <= '0;
         feat_end_time     <= '0;
         feat_span         <= '0;
         feat_sat          <= 1'b0;
      end else if (w_emit_entry) begin
         feat_tx_count     <= w_tx_nxt;
         feat_in_count     <= w_in_nxt;
         feat_method_count <= w_meth_nxt;
         feat_method_seen  <= w_seen_nxt;
         feat_value_sum    <= w_sum_nxt;
         feat_start_time   <= w_start_nxt;
         feat_end_time     <= w_end_nxt;
         feat_span         <= w_end_nxt - w_start_nxt;
         feat_sat          <= w_sat_nxt;
      end
   end

endmodule

// File: tb/tb_wallet_feature_accum.sv
// tb/tb_wallet_feature_accum.sv - scoreboard bench for wallet_feature_accum
module tb_wallet_feature_accum;

   typedef struct {
      int          tx;
      int          inc;
      int          meth;
      bit          seen;
      logic [63:0] sum;
      logic [9:0]  st;
      logic [9:0]  en;
      logic [9:0]  span;
      bit          sat;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic        tx_last = 1'b0;
   logic [9:0]  time_stamp = '0;
   logic        in = 1'b0;
   logic [1:0]  method_field = '0;
   logic [29:0] value = '0;
   logic        feat_valid;
   logic        feat_ready = 1'b1;
   logic [6:0]  feat_tx_count;
   logic [6:0]  feat_in_count;
   logic [6:0]  feat_method_count;
   logic        feat_method_seen;
   logic [63:0] feat_value_sum;
   logic [9:0]  feat_start_time;
   logic [9:0]  feat_end_time;
   logic [9:0]  feat_span;
   logic        feat_sat;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_push = 0;
   int   n_recv = 0;
   rec_t sb[$];
   rec_t m;
   rec_t got;
   bit   m_first = 1'b1;

   wallet_feature_accum dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .tx_last           (tx_last),
      .time_stamp        (time_stamp),
      .in                (in),
      .method_field      (method_field),
      .value             (value),
      .feat_valid        (feat_valid),
      .feat_ready        (feat_ready),
      .feat_tx_count     (feat_tx_count),
      .feat_in_count     (feat_in_count),
      .feat_method_count (feat_method_count),
      .feat_method_seen  (feat_method_seen),
      .feat_value_sum    (feat_value_sum),
      .feat_start_time   (feat_start_time),
      .feat_end_time     (feat_end_time),
      .feat_span         (feat_span),
      .feat_sat          (feat_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_tx(input int ts, input bit i, input int mf, input logic [29:0] v, input bit last);
      logic [64:0] t;
      bit hit;
      hit = (mf == 3);
      if (m_first) begin
         m.tx = 1; m.inc = i; m.meth = hit; m.seen = hit;
         m.sum = {34'd0, v}; m.st = ts[9:0]; m.en = ts[9:0]; m.sat = 1'b0;
         m_first = 1'b0;
      end else begin
         if (m.tx == 127) m.sat = 1'b1; else m.tx++;
         if (i) begin
            if (m.inc == 127) m.sat = 1'b1; else m.inc++;
         end
         if (hit) begin
            if (m.meth == 127) m.sat = 1'b1; else m.meth++;
         end
         m.seen = m.seen | hit;
         t = {1'b0, m.sum} + {35'd0, v};
         if (t[64]) begin m.sum = '1; m.sat = 1'b1; end else m.sum = t[63:0];
         m.en = ts[9:0];
      end
      if (last) begin
         m.span = m.en - m.st;
         sb.push_back(m);
         n_push++;
         m_first = 1'b1;
      end
   endtask

   task automatic drive_tx(input int ts, input bit i, input int mf, input logic [29:0] v, input bit last);
      model_tx(ts, i, mf, v, last);
      tx_valid = 1'b1; time_stamp = ts[9:0]; in = i;
      method_field = mf[1:0]; value = v; tx_last = last;
   endtask

   task automatic send_tx(input int ts, input bit i, input int mf, input logic [29:0] v, input bit last);
      int n;
      drive_tx(ts, i, mf, v, last);
      n = 0;
      @(negedge clk);
      while (!tx_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!tx_ready) chk("tx_accept_timeout", 0, 1);
      @(posedge clk); #1;
      tx_valid = 1'b0; tx_last = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && feat_valid && feat_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_rec", 1, 0);
         end else begin
            got = sb.pop_front();
            n_recv++;
            chk("rec_tx", feat_tx_count, got.tx);
            chk("rec_in", feat_in_count, got.inc);
            chk("rec_meth", feat_method_count, got.meth);
            chk("rec_seen", feat_method_seen, got.seen);
            chk("rec_sum", feat_value_sum, got.sum);
            chk("rec_start", feat_start_time, got.st);
            chk("rec_end", feat_end_time, got.en);
            chk("rec_span", feat_span, got.span);
            chk("rec_sat", feat_sat, got.sat);
         end
      end
   end

   initial begin
      int n;
      // reset
      @(negedge clk);
      chk("rst_feat_valid", feat_valid, 0);
      chk("rst_tx_ready", tx_ready, 0);
      chk("rst_sum", feat_value_sum, 0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      chk("idle_tx_ready", tx_ready, 1);
      chk("idle_feat_valid", feat_valid, 0);

      // single-transaction wallet, latency 1
      @(posedge clk); #1;
      send_tx(5, 1, 3, 30'd100, 1);
      chk("t1_latency", feat_valid, 1);

      // three-transaction wallet
      send_tx(10, 1, 0, 30'd1, 0);
      send_tx(20, 0, 3, 30'd2, 0);
      send_tx(40, 1, 1, 30'd3, 1);

      // timestamp wrap
      send_tx(1000, 0, 0, 30'd9, 0);
      send_tx(8, 0, 0, 30'd4, 1);

      // backpressure with a pending transaction
      send_tx(77, 1, 2, 30'd11, 1);
      feat_ready = 1'b0;
      drive_tx(3, 0, 2, 30'd55, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_tx_ready", tx_ready, 0);
         chk("bp_feat_valid", feat_valid, 1);
         chk("bp_hold_sum", feat_value_sum, sb[0].sum);
         chk("bp_hold_start", feat_start_time, {54'd0, sb[0].st});
         chk("bp_hold_tx", feat_tx_count, sb[0].tx);
      end
      @(posedge clk); #1; feat_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", feat_valid, 1);
      chk("bp_hs_no_bypass", tx_ready, 0);
      @(negedge clk);
      chk("bp_drop_valid", feat_valid, 0);
      chk("bp_idle_ready", tx_ready, 1);
      @(posedge clk); #1; tx_valid = 1'b0; tx_last = 1'b0;
      @(negedge clk);
      chk("bp_pending_emit", feat_valid, 1);
      @(posedge clk); #1;

      // saturation
      for (int k = 0; k < 130; k++) begin
         send_tx(k, 1, 0, 30'h3FFF_FFFF, (k == 129));
      end

      // reset mid-wallet
      send_tx(50, 1, 3, 30'd20, 0);
      send_tx(60, 1, 3, 30'd30, 0);
      rst_n = 1'b0;
      m_first = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("mrst_feat_valid", feat_valid, 0);
         chk("mrst_tx_ready", tx_ready, 0);
         chk("mrst_tx", feat_tx_count, 0);
         chk("mrst_sum", feat_value_sum, 0);
         chk("mrst_end", feat_end_time, 0);
         chk("mrst_sat", feat_sat, 0);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      send_tx(12, 0, 0, 30'd7, 1);

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drained", sb.size(), 0);
      chk("rec_count", n_recv, n_push);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wallet_feature_accum.md
Name: wallet_feature_accum

Overview:
Upstream stage of the confidence scorer. Consumes one wallet's transaction stream (valid/ready, with a last-of-wallet marker) and accumulates per-wallet running statistics. Statistics are method hits, inbound count, value sum, first/last timestamp and transaction count. On the wallet boundary it presents one frozen feature record, under a valid/ready handshake, to the scoring stage.

Parameters:
TS_W, 10, timestamp width
VAL_W, 30, per-transaction value width
CNT_W, 7, width of all per-wallet counters
SUM_W, 64, value-sum accumulator width
METHOD_FLAG, 2'b11, method_field code counted as a suspicious-method hit

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
tx_valid  in  1  transaction present
tx_ready  out  1  block accepts transaction this cycle
tx_last  in  1  accepted transaction is the wallet's last
time_stamp  in  TS_W  transaction timestamp
in  in  1  1 = inbound, 0 = outbound
method_field  in  2  call-method code
value  in  VAL_W  transaction value
feat_valid  out  1  feature record valid
feat_ready  in  1  downstream takes record
feat_tx_count  out  CNT_W  transactions in wallet (saturating)
feat_in_count  out  CNT_W  inbound transactions (saturating)
feat_method_count  out  CNT_W  METHOD_FLAG hits (saturating)
feat_method_seen  out  1  sticky: any METHOD_FLAG hit
feat_value_sum  out  SUM_W  sum of values (saturating)
feat_start_time  out  TS_W  timestamp of first transaction
feat_end_time  out  TS_W  timestamp of last transaction
feat_span  out  TS_W  end minus start, modulo 2^TS_W
feat_sat  out  1  any counter or sum saturated in this wallet

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All feat_* outputs are 0. tx_ready is 0 while rst_n is low. Any partial wallet is discarded.
- Accept: a transaction is accepted when tx_valid && tx_ready at a clock edge. tx_ready is 1 in IDLE and ACCUM and 0 in EMIT.
- IDLE, first accept:
  - Counters load from that single transaction: tx_count=1, in_count=in, method_count=(method_field==METHOD_FLAG), seen likewise.
  - value_sum=value, start=end=time_stamp, sat=0.
  - Next state is EMIT if tx_last, else ACCUM.
- ACCUM, on accept:
  - Counters increment by the same rules; value_sum adds value.
  - end_time takes time_stamp unconditionally; a non-monotonic timestamp is not checked.
  - method_seen is sticky.
  - Next state is EMIT if tx_last, else remain in ACCUM.
- EMIT:
  - feat_valid=1 the cycle after tx_last is accepted (latency 1).
  - All feat_* are registered and held stable while feat_valid is high.
  - feat_span = feat_end_time - feat_start_time, width TS_W, wrap-around allowed.
  - When feat_valid && feat_ready: feat_valid drops next cycle and the state returns to IDLE. Accumulators are not cleared; the next first-accept overwrites them.
  - tx_valid during EMIT stalls: the transaction is not consumed and the upstream holds it.
- Saturation:
  - Counters stick at 2^CNT_W-1. value_sum sticks at 2^SUM_W-1.
  - Any saturation event sets feat_sat for the remainder of that wallet.
- feat_* outputs are updated only on the EMIT entry edge. They keep the previous record in IDLE/ACCUM but feat_valid=0 there.
- Simultaneous feat_ready and tx_valid in EMIT: the record handshake completes; the transaction is not accepted until the next cycle (IDLE, tx_ready=1). There is no same-cycle bypass.
- States are encoded as IDLE=0, ACCUM=1, EMIT=2; 3 is unreachable and recovers to IDLE.

Decomposition:
- Shared package: state enum, TS_W/VAL_W/CNT_W/SUM_W defaults, METHOD_FLAG constant, feature-record struct. The scoring stage imports the same package.
- One sub-module, sat_counter:
  - Width-parameterised, with load, inc and load value.
  - Outputs a saturate pulse.
  - Instantiated three times for tx, in and method counts.
- The value-sum saturating adder stays inline.

Test Plan:
1. Single-transaction wallet: ts=5, in=1, method=3, value=100, tx_last=1, feat_ready=1 -> feat_valid one cycle later. Record: tx=1, in=1, method=1, seen=1, sum=100, start=end=5, span=0, sat=0.
2. Three transactions: ts 10/20/40, in 1/0/1, method 0/3/1, values 1/2/3, last on the third -> tx=3, in=2, method=1, seen=1, sum=6, start=10, end=40, span=30.
3. Timestamp wrap: ts 1000 then 8 (last) -> start=1000, end=8, span=32.
4. Backpressure: feat_ready=0 for 5 cycles after EMIT with tx_valid=1 pending -> tx_ready=0 and the record is bit-stable for 5 cycles. Raise feat_ready -> feat_valid drops next cycle and the pending transaction is accepted in IDLE the cycle after.
5. Saturation: 130 inbound transactions, value=2^30-1 each, last on the 130th -> tx=127, in=127, sat=1, sum=130*(2^30-1) (no sum saturation).
6. Reset mid-wallet: two transactions accepted, then rst_n low for 2 cycles -> feat_valid=0, tx_ready=0, and all feat_* are 0 during reset. The next wallet (1 transaction, value=7, last) emits tx=1, sum=7.
